// File: rtl/alu_seq_muldiv_if.sv
// Bus between the EX-stage control FSM and alu_seq_muldiv.
// Defining ALU_OVERFLOW_EN adds the ovf signal.
interface alu_seq_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       func_field;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef ALU_OVERFLOW_EN
  logic             ovf;

  modport master (output start, opcode, func_field, A, B,
                  input  result, zero, busy, done, hi, lo, ovf);
  modport slave  (input  start, opcode, func_field, A, B,
                  output result, zero, busy, done, hi, lo, ovf);
`else
  modport master (output start, opcode, func_field, A, B,
                  input  result, zero, busy, done, hi, lo);
  modport slave  (input  start, opcode, func_field, A, B,
                  output result, zero, busy, done, hi, lo);
`endif
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered MIPS ALU with iterative mult/div and HI/LO registers.
// Optional macro ALU_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_seq_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] result_r, hi_r, lo_r;
  logic             zero_r, done_r;
  logic [WIDTH-1:0] hi_acc, lo_acc, opnd;
  logic             op_mul, neg_p, neg_r;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             is_multi, is_mul, is_sgn;

  logic [WIDTH:0]   msum, rsh, trial;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE2;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  assign a_s  = bus.A;
  assign b_s  = bus.B;
  assign sum  = bus.A + bus.B;
  assign diff = bus.A - bus.B;

  always_comb begin
    alu_res  = '0;
    is_multi = 1'b0;
    is_mul   = 1'b0;
    is_sgn   = 1'b0;
    case (bus.opcode)
      6'h00: begin
        case (bus.func_field)
          6'h20, 6'h21: alu_res = sum;
          6'h22, 6'h23: alu_res = diff;
          6'h24: alu_res = bus.A & bus.B;
          6'h25: alu_res = bus.A | bus.B;
          6'h26: alu_res = bus.A ^ bus.B;
          6'h27: alu_res = ~(bus.A | bus.B);
          6'h2A: alu_res = (a_s < b_s) ? ONE : '0;
          6'h2B: alu_res = (bus.A < bus.B) ? ONE : '0;
          6'h10: alu_res = hi_r;
          6'h12: alu_res = lo_r;
          6'h18: begin is_multi = 1'b1; is_mul = 1'b1; is_sgn = 1'b1; end
          6'h19: begin is_multi = 1'b1; is_mul = 1'b1; end
          6'h1A: begin is_multi = 1'b1; is_sgn = 1'b1; end
          6'h1B: is_multi = 1'b1;
          default: alu_res = '0;
        endcase
      end
      6'h23, 6'h2B, 6'h08, 6'h09: alu_res = sum;
      6'h04, 6'h05: alu_res = diff;
      6'h0C: alu_res = bus.A & bus.B;
      6'h0D: alu_res = bus.A | bus.B;
      default: alu_res = '0;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    msum  = {1'b0, hi_acc} + {1'b0, (lo_acc[0] ? opnd : '0)};
    rsh   = {hi_acc, lo_acc[WIDTH-1]};
    trial = rsh - {1'b0, opnd};
    if (op_mul) begin
      it_hi = msum[WIDTH:1];
      it_lo = {msum[0], lo_acc[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      it_hi = trial[WIDTH-1:0];
      it_lo = {lo_acc[WIDTH-2:0], 1'b1};
    end else begin
      it_hi = rsh[WIDTH-1:0];
      it_lo = {lo_acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction; a zero divisor leaves remainder = A and forces quotient to all ones
  always_comb begin
    prod_fix = neg_p ? neg_2w({hi_acc, lo_acc}) : {hi_acc, lo_acc};
    if (op_mul) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else begin
      fix_hi = neg_r ? neg_w(hi_acc) : hi_acc;
      fix_lo = (opnd == '0) ? '1 : (neg_p ? neg_w(lo_acc) : lo_acc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && is_multi) state_nxt = RUN;
      RUN:     if (count == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_r, ovf_nxt, add_ovf, sub_ovf;

  always_comb begin
    add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
    sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
    ovf_nxt = 1'b0;
    if ((bus.opcode == 6'h00 && bus.func_field == 6'h20) || bus.opcode == 6'h08)
      ovf_nxt = add_ovf;
    else if (bus.opcode == 6'h00 && bus.func_field == 6'h22)
      ovf_nxt = sub_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_r <= 1'b0;
    else if (state == IDLE && bus.start)
      ovf_r <= is_multi ? 1'b0 : ovf_nxt;
  end

  assign bus.ovf = ovf_r;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r <= '0;
      zero_r   <= 1'b1;
      done_r   <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      hi_acc   <= '0;
      lo_acc   <= '0;
      opnd     <= '0;
      count    <= '0;
      op_mul   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (is_multi) begin
            hi_acc <= '0;
            lo_acc <= is_mul ? mag(bus.B, is_sgn) : mag(bus.A, is_sgn);
            opnd   <= is_mul ? mag(bus.A, is_sgn) : mag(bus.B, is_sgn);
            op_mul <= is_mul;
            neg_p  <= is_sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r  <= is_sgn && bus.A[WIDTH-1];
            count  <= '0;
          end else begin
            result_r <= alu_res;
            zero_r   <= (alu_res == '0);
            done_r   <= 1'b1;
          end
        end
        RUN: begin
          hi_acc <= it_hi;
          lo_acc <= it_lo;
          count  <= count + CNT_W'(1);
        end
        FIX: begin
          hi_r     <= fix_hi;
          lo_r     <= fix_lo;
          result_r <= fix_lo;
          zero_r   <= (fix_lo == '0);
          done_r   <= 1'b1;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.zero   = zero_r;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
endmodule
